// File: rtl/fp16_to_int32_pipe.sv
// FP16 -> signed INT32 converter: round-half-away(fp16 * 2^shift), saturating, with a saturation event counter.
// Latency 3 cycles, 1 beat/clock; stall ripples back combinationally from out_ready, no skid buffer.
module fp16_to_int32_pipe #(
    parameter int SATCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         in_fp16,
    input  logic [5:0]          in_shift,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_int32,
    output logic                out_sat,
    output logic                out_nan,
    input  logic                sat_clr,
    output logic [SATCNT_W-1:0] sat_count
);

    logic en1, en2, en3;
    logic v1, v2;

    assign en3      = ~out_valid | out_ready;
    assign en2      = ~v2 | en3;
    assign en1      = ~v1 | en2;
    assign in_ready = en1;

    // Stage 1: decode into integer mantissa M and net binary exponent s.
    logic [4:0]        exp_in;
    logic [9:0]        mant_in;
    logic signed [7:0] e_in, s_in;

    assign exp_in  = in_fp16[14:10];
    assign mant_in = in_fp16[9:0];

    always_comb begin
        e_in = (exp_in == 5'd0) ? -8'sd24 : ($signed({3'b000, exp_in}) - 8'sd25);
        s_in = e_in + $signed({{2{in_shift[5]}}, in_shift});
    end

    logic              sign1, nan1, inf1;
    logic [10:0]       m1;
    logic signed [7:0] s1;

    // Stage 2: shift magnitude; right shifts round half away from zero.
    logic [63:0] m_ext, half, mag_c;
    logic [7:0]  n;

    always_comb begin
        m_ext = {53'd0, m1};
        n     = 8'(-s1);
        half  = m_ext >> (n - 8'd1);
        mag_c = 64'd0;
        if (!s1[7])
            mag_c = m_ext << s1;
        else if (s1 >= -8'sd12)
            mag_c = (half >> 1) + {63'd0, half[0]};
    end

    logic        sign2, nan2, inf2;
    logic [63:0] mag2;

    // Stage 3: apply sign and clip to the INT32 range.
    logic [31:0] res_c;
    logic        sat_c, nan_c;

    always_comb begin
        res_c = sign2 ? (~mag2[31:0] + 32'd1) : mag2[31:0];
        sat_c = 1'b0;
        nan_c = 1'b0;
        if (nan2) begin
            res_c = 32'd0;
            nan_c = 1'b1;
        end else if (inf2 || (!sign2 && mag2 > 64'h7FFF_FFFF) || (sign2 && mag2 > 64'h8000_0000)) begin
            res_c = sign2 ? 32'h8000_0000 : 32'h7FFF_FFFF;
            sat_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            sign1     <= 1'b0;
            nan1      <= 1'b0;
            inf1      <= 1'b0;
            m1        <= 11'd0;
            s1        <= 8'sd0;
            v2        <= 1'b0;
            sign2     <= 1'b0;
            nan2      <= 1'b0;
            inf2      <= 1'b0;
            mag2      <= 64'd0;
            out_valid <= 1'b0;
            out_int32 <= 32'd0;
            out_sat   <= 1'b0;
            out_nan   <= 1'b0;
        end else begin
            if (en1) begin
                v1    <= in_valid;
                sign1 <= in_fp16[15];
                m1    <= {exp_in != 5'd0, mant_in};
                s1    <= s_in;
                nan1  <= (exp_in == 5'h1F) && (mant_in != 10'd0);
                inf1  <= (exp_in == 5'h1F) && (mant_in == 10'd0);
            end
            if (en2) begin
                v2    <= v1;
                sign2 <= sign1;
                mag2  <= mag_c;
                nan2  <= nan1;
                inf2  <= inf1;
            end
            if (en3) begin
                out_valid <= v2;
                out_int32 <= res_c;
                out_sat   <= sat_c;
                out_nan   <= nan_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || sat_clr)
            sat_count <= '0;
        else if (out_valid && out_ready && out_sat && !(&sat_count))
            sat_count <= sat_count + SATCNT_W'(1);
    end

endmodule

// File: tb/tb_fp16_to_int32_pipe.sv
// Randomized + directed bench for fp16_to_int32_pipe against a real-arithmetic reference model.
module tb_fp16_to_int32_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_fp16 = 16'd0;
    logic [5:0]  in_shift = 6'd0;
    logic        out_ready = 1'b1;
    logic        sat_clr = 1'b0;

    logic        in_ready, out_valid, out_sat, out_nan;
    logic [31:0] out_int32;
    logic [15:0] sat_count1;
    logic        in_ready2, out_valid2, out_sat2, out_nan2;
    logic [31:0] out_int32_2;
    logic [1:0]  sat_count2;

    fp16_to_int32_pipe #(.SATCNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fp16(in_fp16), .in_shift(in_shift), .out_valid(out_valid), .out_ready(out_ready),
        .out_int32(out_int32), .out_sat(out_sat), .out_nan(out_nan),
        .sat_clr(sat_clr), .sat_count(sat_count1)
    );

    fp16_to_int32_pipe #(.SATCNT_W(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_fp16(in_fp16), .in_shift(in_shift), .out_valid(out_valid2), .out_ready(out_ready),
        .out_int32(out_int32_2), .out_sat(out_sat2), .out_nan(out_nan2),
        .sat_clr(sat_clr), .sat_count(sat_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        sat;
        logic        nan;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, acc_cyc = 0, n_acc = 0, n_out = 0;
    int   cnt1 = 0, cnt2 = 0;
    logic done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic real pow2(input int k);
        real p = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
        else        for (int i = 0; i < -k; i++) p = p * 0.5;
        return p;
    endfunction

    // Reference: exact real value times 2^shift, rounded half away from zero, clipped to INT32.
    function automatic exp_t model(input logic [15:0] f, input logic [5:0] shb);
        exp_t   e;
        int     ex, mt, sh;
        real    a, rr;
        longint m;
        ex = int'(f[14:10]);
        mt = int'(f[9:0]);
        sh = int'($signed(shb));
        e.r = 32'd0; e.sat = 1'b0; e.nan = 1'b0;
        if (ex == 31) begin
            if (mt != 0) e.nan = 1'b1;
            else begin
                e.sat = 1'b1;
                e.r   = f[15] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
            return e;
        end
        a  = (ex == 0) ? (mt * pow2(-24)) : ((1024 + mt) * pow2(ex - 25));
        a  = a * pow2(sh);
        rr = $floor(a + 0.5);
        if (!f[15] && rr > 2147483647.0) begin
            e.sat = 1'b1; e.r = 32'h7FFF_FFFF;
        end else if (f[15] && rr > 2147483648.0) begin
            e.sat = 1'b1; e.r = 32'h8000_0000;
        end else begin
            m = longint'(rr);
            if (f[15]) m = -m;
            e.r = m[31:0];
        end
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: every visible output must match the head of the expected queue, stalled or not.
    always @(negedge clk) begin
        logic hs_sat;
        exp_t e;
        hs_sat = 1'b0;
        if (!rst_n) begin
            q.delete();
            cnt1 = 0;
            cnt2 = 0;
        end else begin
            chk("sat_count", 64'(sat_count1), 64'(cnt1));
            chk("sat_count_w2", 64'(sat_count2), 64'(cnt2));
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
                else begin
                    chk("out_int32", 64'(out_int32), 64'(q[0].r));
                    chk("out_sat", 64'(out_sat), 64'(q[0].sat));
                    chk("out_nan", 64'(out_nan), 64'(q[0].nan));
                    if (out_ready) begin
                        hs_sat = q[0].sat;
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (sat_clr) begin
                cnt1 = 0; cnt2 = 0;
            end else if (hs_sat) begin
                if (cnt1 < 65535) cnt1++;
                if (cnt2 < 3) cnt2++;
            end
            if (in_valid && in_ready) begin
                e = model(in_fp16, in_shift);
                q.push_back(e);
                n_acc++;
            end
        end
    end

    task automatic send(input logic [15:0] f, input logic [5:0] sh);
        int t = 0;
        in_fp16 = f; in_shift = sh; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", 64'd1, 64'd0);
        acc_cyc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk(tag, 64'd0, 64'd1);
    endtask

    task automatic run_vec(input logic [15:0] f, input logic [5:0] sh, input logic [31:0] r,
                           input logic sat, input logic nan);
        out_ready = 1'b1;
        send(f, sh);
        wait_out("vec_timeout");
        chk("vec_int32", 64'(out_int32), 64'(r));
        chk("vec_sat", 64'(out_sat), 64'(sat));
        chk("vec_nan", 64'(out_nan), 64'(nan));
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rand_fp16();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 3) == 0) v[9:0] = 10'd0;
        return v;
    endfunction

    initial begin
        int base, t;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_int32", 64'(out_int32), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_out_nan", 64'(out_nan), 64'd0);
        chk("rst_sat_count", 64'(sat_count1), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Latency of first beat with no stall.
        send(16'h3C00, 6'd0);
        wait_out("latency_timeout");
        chk("latency", 64'(cyc - acc_cyc), 64'd3);
        @(posedge clk); #1;

        run_vec(16'h3E00, 6'd0,  32'h0000_0002, 1'b0, 1'b0);
        run_vec(16'hBE00, 6'd0,  32'hFFFF_FFFE, 1'b0, 1'b0);
        run_vec(16'h3800, 6'd0,  32'h0000_0001, 1'b0, 1'b0);
        run_vec(16'h3400, 6'd0,  32'h0000_0000, 1'b0, 1'b0);
        run_vec(16'h8000, 6'd0,  32'h0000_0000, 1'b0, 1'b0);
        run_vec(16'h7BFF, 6'd15, 32'h7FF0_0000, 1'b0, 1'b0);
        run_vec(16'h7BFF, 6'd16, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_vec(16'hC000, 6'd30, 32'h8000_0000, 1'b0, 1'b0);
        run_vec(16'hC000, 6'd31, 32'h8000_0000, 1'b1, 1'b0);
        run_vec(16'h0001, 6'd24, 32'h0000_0001, 1'b0, 1'b0);
        run_vec(16'h3C00, 6'h20, 32'h0000_0000, 1'b0, 1'b0);

        sat_clr = 1'b1;
        @(posedge clk); #1 sat_clr = 1'b0;
        run_vec(16'h7C00, 6'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_vec(16'hFC00, 6'd0, 32'h8000_0000, 1'b1, 1'b0);
        run_vec(16'h7E00, 6'd0, 32'h0000_0000, 1'b0, 1'b1);
        @(negedge clk);
        chk("specials_sat_count", 64'(sat_count1), 64'd2);
        @(posedge clk); #1;

        // Backpressure: 6 beats against a 5-cycle stall.
        base = n_acc;
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send(16'h3C00, 6'(i));
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("bp_accepted", 64'(n_acc - base), 64'd3);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_held_valid", 64'(out_valid), 64'd1);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        base = n_out;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_drained", 64'(q.size()), 64'd0);
        chk("bp_out_count", 64'(n_out - base + 3), 64'd6);
        @(posedge clk); #1;

        // Narrow counter sticks at all-ones.
        for (int i = 0; i < 5; i++) run_vec(16'h7C00, 6'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        @(negedge clk);
        chk("w2_sat_hold", 64'(sat_count2), 64'd3);
        @(posedge clk); #1;

        // Clear coincident with a saturating output handshake.
        out_ready = 1'b0;
        send(16'hFC00, 6'd0);
        wait_out("clr_timeout");
        @(posedge clk); #1 begin out_ready = 1'b1; sat_clr = 1'b1; end
        @(posedge clk); #1 sat_clr = 1'b0;
        @(negedge clk);
        chk("clr_prio_16", 64'(sat_count1), 64'd0);
        chk("clr_prio_w2", 64'(sat_count2), 64'd0);
        @(posedge clk); #1;

        // Reset with three beats in flight.
        send(16'h3C00, 6'd1);
        send(16'h3C00, 6'd2);
        send(16'h3C00, 6'd3);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        run_vec(16'h4000, 6'd2, 32'h0000_0008, 1'b0, 1'b0);

        // Randomized traffic with random stalls and clears.
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(rand_fp16(), 6'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    sat_clr   = ($urandom_range(0, 31) == 0);
                end
                out_ready = 1'b1;
                sat_clr   = 1'b0;
            end
        join
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rand_drained", 64'(q.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
